mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the processor's single memory port between the instruction-fetch requester and the data-access requester of the MEM stage. Each transaction is serialised through a small FSM with a per-transaction timeout. The block raises a stall request to the pipeline controller while any requester is still waiting. It sits between the core top level (fetch and MEM stages) and the external memory/bus.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 16, max cycles waiting for `m_ack_i` before abort; 0 disables timeout
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `if_req_i` in 1: fetch request, held until `if_ack_o`
- `if_addr_i` in AW: fetch address
- `if_rdata_o` out DW: fetched instruction, valid with `if_ack_o`
- `if_ack_o` out 1: fetch complete, one-cycle pulse
- `d_req_i` in 1: data request, held until `d_ack_o`
- `d_we_i` in 1: 1 = write, 0 = read
- `d_sel_i` in DW/8: byte enables
- `d_addr_i` in AW: data address
- `d_wdata_i` in DW: write data
- `d_rdata_o` out DW: read data, valid with `d_ack_o`
- `d_ack_o` out 1: data complete, one-cycle pulse
- `m_ce_o` out 1: memory cycle active
- `m_we_o` out 1: memory write
- `m_sel_o` out DW/8: memory byte enables
- `m_addr_o` out AW: memory address
- `m_wdata_o` out DW: memory write data
- `m_rdata_i` in DW: memory read data
- `m_ack_i` in 1: memory completes the current cycle
- `stall_req_o` out 1: pipeline stall request
- `err_o` out 1: timeout abort, one-cycle pulse

## Operation
- **FSM states:** IDLE, IF_BUSY, D_BUSY, DONE.
- **IDLE:**
  - `d_req_i` → D_BUSY. Data has fixed priority because it belongs to the older instruction.
  - Else `if_req_i` → IF_BUSY.
  - Else stay.
- **Grant entry:** on entering a BUSY state, register the winner's address, `we`, `sel` and `wdata` onto the `m_*` outputs. Set `m_ce_o` = 1. Clear the timeout counter.
  - Fetch grants drive `m_we_o` = 0 and `m_sel_o` = all ones.
- **BUSY:** hold every `m_*` output stable until `m_ack_i`.
- **On `m_ack_i`:**
  - Capture `m_rdata_i` into the granted requester's `rdata_o`. Capture it even on writes.
  - Pulse that requester's `ack_o` next cycle.
  - Clear `m_ce_o` and `m_we_o`, and go to DONE.
- **Timeout:** counter increments each BUSY cycle without `m_ack_i`.
  - On reaching `TIMEOUT`-1 with `TIMEOUT` ≠ 0: abort.
  - Abort does the same as an ack, except `rdata_o` = 0 and `err_o` pulses together with `ack_o`.
  - A `m_ack_i` arriving in the abort cycle counts as a normal ack: no `err_o`.
- **DONE:**
  - `ack_o` is high during this cycle. Requests are not sampled, which prevents a re-grant of the request being retired.
  - Next state is IDLE.
- **Stall:** `stall_req_o` = (`if_req_i` & ~`if_ack_o`) | (`d_req_i` & ~`d_ack_o`). This is the only combinational output.
- **Requester contract:**
  - `*_addr`/`we`/`sel`/`wdata` stay stable while `req` is high.
  - `req` is dropped, or changed to a new request, after the `ack` cycle.
- **Request withdrawal:** a requester dropping `req` while granted does not abort the memory cycle. It completes and its `ack` is still pulsed.

## Timing
- **Reset (`rst` low):**
  - State IDLE, counter 0.
  - All registered outputs are 0: `m_*`, `if_rdata_o`, `d_rdata_o`, `if_ack_o`, `d_ack_o`, `err_o`.
  - Reset mid-transaction drops `m_ce_o` immediately and produces no `ack`.
- **Latency:**
  - `req` seen in IDLE at cycle T gives `m_ce_o` at T+1.
  - `m_ack_i` at cycle A gives `ack_o` and data at A+1.
  - Zero-wait memory (`m_ack_i` at T+1): `ack_o` at T+2.
- **Throughput:** one transaction per 3 cycles with zero-wait memory (BUSY, DONE, IDLE).
- **Both requests high in IDLE:** data first. Fetch is granted in the IDLE cycle after data's DONE.
- **Fetch already granted when `d_req_i` rises:** fetch completes first. No preemption.
- **Timeout at `TIMEOUT` = 16:** `m_ce_o` is high for exactly 16 cycles. `ack_o` and `err_o` rise the cycle after the 16th.

## Test plan
- **Single fetch:** `if_req_i` = 1, addr 0x100, zero-wait memory returns 0x3C010101 → `m_ce_o` high 1 cycle, `if_ack_o` 2 cycles after the request with `if_rdata_o` = 0x3C010101, `stall_req_o` high until the ack.
- **Simultaneous requests:** `if_req_i` and `d_req_i` both high, data write addr 0x200 data 0xDEADBEEF sel 0xF → memory first sees `m_we_o` = 1 at 0x200, `d_ack_o` first, then the fetch at `if_addr_i`, `if_ack_o` 3 cycles after `d_ack_o`.
- **Wait states:** memory acks 4 cycles after `m_ce_o` → `m_*` stable for all 4 cycles, exactly one `ack_o` pulse, no `err_o`.
- **Timeout:** memory never acks, `TIMEOUT` = 16 → `m_ce_o` high 16 cycles, then `d_ack_o` = `err_o` = 1 for one cycle with `d_rdata_o` = 0, FSM back to IDLE.
- **Reset mid-operation:** assert `rst` low during D_BUSY → `m_ce_o`, `d_ack_o` and `stall`-related state clear asynchronously. After release, a held `if_req_i` is served normally.
- **Held request:** back-to-back fetches with `if_req_i` held high and `if_addr_i` advancing after each ack → no duplicate grants, one memory cycle per ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data-access requests onto a single memory port.
// Data requests win in IDLE; each granted cycle is bounded by an optional timeout.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic [DW-1:0]   if_rdata_o,
  output logic            if_ack_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [DW/8-1:0] d_sel_i,
  input  logic [AW-1:0]   d_addr_i,
  input  logic [DW-1:0]   d_wdata_i,
  output logic [DW-1:0]   d_rdata_o,
  output logic            d_ack_o,
  output logic            m_ce_o,
  output logic            m_we_o,
  output logic [DW/8-1:0] m_sel_o,
  output logic [AW-1:0]   m_addr_o,
  output logic [DW-1:0]   m_wdata_o,
  input  logic [DW-1:0]   m_rdata_i,
  input  logic            m_ack_i,
  output logic            stall_req_o,
  output logic            err_o
);

  localparam int SW = DW / 8;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic            busy_s, timeout_s, finish_s;
  logic            m_ce_nxt_s, m_we_nxt_s;
  logic [SW-1:0]   m_sel_nxt_s;
  logic [AW-1:0]   m_addr_nxt_s;
  logic [DW-1:0]   m_wdata_nxt_s, if_rdata_nxt_s, d_rdata_nxt_s;
  logic            if_ack_nxt_s, d_ack_nxt_s, err_nxt_s;

  assign busy_s    = (state_r == IF_BUSY) || (state_r == D_BUSY);
  // An ack arriving in the last allowed cycle takes precedence over the abort.
  assign timeout_s = (TIMEOUT != 0) && busy_s && !m_ack_i && (cnt_r == TO_LAST);
  assign finish_s  = busy_s && (m_ack_i || timeout_s);

  assign stall_req_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (d_req_i) begin
          state_nxt_s = D_BUSY;
        end else if (if_req_i) begin
          state_nxt_s = IF_BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (finish_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values for the registered outputs and the timeout counter
  always_comb begin
    m_ce_nxt_s     = m_ce_o;
    m_we_nxt_s     = m_we_o;
    m_sel_nxt_s    = m_sel_o;
    m_addr_nxt_s   = m_addr_o;
    m_wdata_nxt_s  = m_wdata_o;
    if_rdata_nxt_s = if_rdata_o;
    d_rdata_nxt_s  = d_rdata_o;
    if_ack_nxt_s   = 1'b0;
    d_ack_nxt_s    = 1'b0;
    err_nxt_s      = 1'b0;
    cnt_nxt_s      = cnt_r;
    case (state_r)
      IDLE: begin
        if (d_req_i) begin
          m_ce_nxt_s    = 1'b1;
          m_we_nxt_s    = d_we_i;
          m_sel_nxt_s   = d_sel_i;
          m_addr_nxt_s  = d_addr_i;
          m_wdata_nxt_s = d_wdata_i;
          cnt_nxt_s     = {CW{1'b0}};
        end else if (if_req_i) begin
          m_ce_nxt_s    = 1'b1;
          m_we_nxt_s    = 1'b0;
          m_sel_nxt_s   = {SW{1'b1}};
          m_addr_nxt_s  = if_addr_i;
          m_wdata_nxt_s = {DW{1'b0}};
          cnt_nxt_s     = {CW{1'b0}};
        end else begin
          cnt_nxt_s     = cnt_r;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (finish_s) begin
          m_ce_nxt_s = 1'b0;
          m_we_nxt_s = 1'b0;
          err_nxt_s  = timeout_s;
          if (state_r == IF_BUSY) begin
            if_ack_nxt_s   = 1'b1;
            if_rdata_nxt_s = m_ack_i ? m_rdata_i : {DW{1'b0}};
          end else begin
            d_ack_nxt_s    = 1'b1;
            d_rdata_nxt_s  = m_ack_i ? m_rdata_i : {DW{1'b0}};
          end
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      DONE:    cnt_nxt_s = cnt_r;
      default: cnt_nxt_s = {CW{1'b0}};
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r      <= {CW{1'b0}};
      m_ce_o     <= 1'b0;
      m_we_o     <= 1'b0;
      m_sel_o    <= {SW{1'b0}};
      m_addr_o   <= {AW{1'b0}};
      m_wdata_o  <= {DW{1'b0}};
      if_rdata_o <= {DW{1'b0}};
      d_rdata_o  <= {DW{1'b0}};
      if_ack_o   <= 1'b0;
      d_ack_o    <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      m_ce_o     <= m_ce_nxt_s;
      m_we_o     <= m_we_nxt_s;
      m_sel_o    <= m_sel_nxt_s;
      m_addr_o   <= m_addr_nxt_s;
      m_wdata_o  <= m_wdata_nxt_s;
      if_rdata_o <= if_rdata_nxt_s;
      d_rdata_o  <= d_rdata_nxt_s;
      if_ack_o   <= if_ack_nxt_s;
      d_ack_o    <= d_ack_nxt_s;
      err_o      <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, d_req_i, d_we_i, m_ack_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i, m_rdata_i;
  logic [3:0]  d_sel_i;
  logic [31:0] if_rdata_o, d_rdata_o, m_addr_o, m_wdata_o;
  logic [3:0]  m_sel_o;
  logic        if_ack_o, d_ack_o, m_ce_o, m_we_o, stall_req_o, err_o;

  int pass_cnt = 0;
  int total    = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .m_ce_o(m_ce_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_rdata_i(m_rdata_i), .m_ack_i(m_ack_i),
    .stall_req_o(stall_req_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0; m_ack_i = 1'b0;
    if_addr_i = 32'h0; d_addr_i = 32'h0; d_wdata_i = 32'h0; m_rdata_i = 32'h0; d_sel_i = 4'h0;
    tick(); tick();
    total++; if ({m_ce_o, m_we_o, if_ack_o, d_ack_o, err_o, stall_req_o} !== 6'b0)
      $display("FAIL reset_ctrl act=%b exp=000000", {m_ce_o, m_we_o, if_ack_o, d_ack_o, err_o, stall_req_o}); else pass_cnt++;
    total++; if ({m_addr_o, m_wdata_o, m_sel_o, if_rdata_o, d_rdata_o} !== 132'h0)
      $display("FAIL reset_data act=%h exp=0", {m_addr_o, m_wdata_o, m_sel_o, if_rdata_o, d_rdata_o}); else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    tick();
    total++; if (m_ce_o !== 1'b0) $display("FAIL reset_idle_ce act=%b exp=0", m_ce_o); else pass_cnt++;
  endtask

  task automatic test_single_fetch();
    if_req_i = 1'b1; if_addr_i = 32'h100; m_rdata_i = 32'h3C010101;
    #1;
    total++; if (stall_req_o !== 1'b1) $display("FAIL fetch_stall_req act=%b exp=1", stall_req_o); else pass_cnt++;
    tick();
    total++; if ({m_ce_o, m_we_o, m_sel_o, m_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h100})
      $display("FAIL fetch_grant act=%b%b %h %h exp=10 f 00000100", m_ce_o, m_we_o, m_sel_o, m_addr_o); else pass_cnt++;
    total++; if ({if_ack_o, stall_req_o} !== 2'b01) $display("FAIL fetch_busy_ack act=%b exp=01", {if_ack_o, stall_req_o}); else pass_cnt++;
    m_ack_i = 1'b1;
    tick();
    m_ack_i = 1'b0;
    total++; if ({if_ack_o, m_ce_o, if_rdata_o} !== {1'b1, 1'b0, 32'h3C010101})
      $display("FAIL fetch_ack act=%b%b %h exp=10 3c010101", if_ack_o, m_ce_o, if_rdata_o); else pass_cnt++;
    total++; if (stall_req_o !== 1'b0) $display("FAIL fetch_stall_ack act=%b exp=0", stall_req_o); else pass_cnt++;
    if_req_i = 1'b0;
    tick();
    total++; if ({if_ack_o, m_ce_o} !== 2'b00) $display("FAIL fetch_idle act=%b exp=00", {if_ack_o, m_ce_o}); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    if_req_i = 1'b1; if_addr_i = 32'h300;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h200; d_wdata_i = 32'hDEADBEEF; d_sel_i = 4'hF;
    tick();
    total++; if ({m_ce_o, m_we_o, m_sel_o, m_addr_o, m_wdata_o} !== {1'b1, 1'b1, 4'hF, 32'h200, 32'hDEADBEEF})
      $display("FAIL sim_data_grant act=%b%b %h %h %h exp=11 f 00000200 deadbeef", m_ce_o, m_we_o, m_sel_o, m_addr_o, m_wdata_o); else pass_cnt++;
    m_ack_i = 1'b1; m_rdata_i = 32'h11111111;
    tick();
    m_ack_i = 1'b0; d_req_i = 1'b0;
    total++; if ({d_ack_o, if_ack_o, m_ce_o, m_we_o, d_rdata_o} !== {4'b1000, 32'h11111111})
      $display("FAIL sim_data_ack act=%b %h exp=1000 11111111", {d_ack_o, if_ack_o, m_ce_o, m_we_o}, d_rdata_o); else pass_cnt++;
    #1;
    total++; if (stall_req_o !== 1'b1) $display("FAIL sim_stall_fetch act=%b exp=1", stall_req_o); else pass_cnt++;
    tick();
    total++; if ({d_ack_o, m_ce_o} !== 2'b00) $display("FAIL sim_idle act=%b exp=00", {d_ack_o, m_ce_o}); else pass_cnt++;
    tick();
    total++; if ({m_ce_o, m_we_o, m_sel_o, m_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h300})
      $display("FAIL sim_fetch_grant act=%b%b %h %h exp=10 f 00000300", m_ce_o, m_we_o, m_sel_o, m_addr_o); else pass_cnt++;
    m_ack_i = 1'b1; m_rdata_i = 32'h22222222;
    tick();
    m_ack_i = 1'b0; if_req_i = 1'b0;
    total++; if ({if_ack_o, d_ack_o, if_rdata_o} !== {2'b10, 32'h22222222})
      $display("FAIL sim_fetch_ack act=%b %h exp=10 22222222", {if_ack_o, d_ack_o}, if_rdata_o); else pass_cnt++;
    tick();
  endtask

  task automatic test_wait_states();
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h400; d_sel_i = 4'h3; d_wdata_i = 32'h0;
    m_rdata_i = 32'h0BADF00D;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if ({m_ce_o, m_we_o, m_sel_o, m_addr_o, d_ack_o, err_o} !== {2'b10, 4'h3, 32'h400, 2'b00})
        $display("FAIL wait_hold_%0d act=%b%b %h %h %b%b exp=10 3 00000400 00", i, m_ce_o, m_we_o, m_sel_o, m_addr_o, d_ack_o, err_o); else pass_cnt++;
      if (i == 3) m_ack_i = 1'b1;
      tick();
    end
    m_ack_i = 1'b0; d_req_i = 1'b0;
    total++; if ({d_ack_o, err_o, m_ce_o, d_rdata_o} !== {3'b100, 32'h0BADF00D})
      $display("FAIL wait_ack act=%b %h exp=100 0badf00d", {d_ack_o, err_o, m_ce_o}, d_rdata_o); else pass_cnt++;
    tick();
    total++; if ({d_ack_o, err_o} !== 2'b00) $display("FAIL wait_single_pulse act=%b exp=00", {d_ack_o, err_o}); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n = 0;
    logic err_seen = 1'b0;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h500; d_sel_i = 4'hF; m_rdata_i = 32'hFFFFFFFF;
    tick();
    while (m_ce_o === 1'b1 && n < 40) begin
      if (err_o !== 1'b0 || d_ack_o !== 1'b0) err_seen = 1'b1;
      n++;
      tick();
    end
    d_req_i = 1'b0;
    total++; if (n !== 16) $display("FAIL timeout_ce_cycles act=%0d exp=16", n); else pass_cnt++;
    total++; if (err_seen !== 1'b0) $display("FAIL timeout_early_pulse act=%b exp=0", err_seen); else pass_cnt++;
    total++; if ({d_ack_o, err_o, d_rdata_o} !== {2'b11, 32'h0})
      $display("FAIL timeout_abort act=%b %h exp=11 00000000", {d_ack_o, err_o}, d_rdata_o); else pass_cnt++;
    tick();
    total++; if ({d_ack_o, err_o, m_ce_o} !== 3'b000) $display("FAIL timeout_idle act=%b exp=000", {d_ack_o, err_o, m_ce_o}); else pass_cnt++;
  endtask

  task automatic test_ack_at_limit();
    d_req_i = 1'b1; d_addr_i = 32'h580; m_rdata_i = 32'h12345678;
    tick();
    for (int i = 0; i < 15; i++) tick();
    total++; if (m_ce_o !== 1'b1) $display("FAIL limit_ce_still act=%b exp=1", m_ce_o); else pass_cnt++;
    m_ack_i = 1'b1;
    tick();
    m_ack_i = 1'b0; d_req_i = 1'b0;
    total++; if ({d_ack_o, err_o, d_rdata_o} !== {2'b10, 32'h12345678})
      $display("FAIL limit_ack act=%b %h exp=10 12345678", {d_ack_o, err_o}, d_rdata_o); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h600;
    tick();
    total++; if (m_ce_o !== 1'b1) $display("FAIL rstmid_grant act=%b exp=1", m_ce_o); else pass_cnt++;
    if_req_i = 1'b1; if_addr_i = 32'h700;
    #2 rst = 1'b0;
    #1;
    total++; if ({m_ce_o, d_ack_o, err_o} !== 3'b000) $display("FAIL rstmid_async act=%b exp=000", {m_ce_o, d_ack_o, err_o}); else pass_cnt++;
    d_req_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    tick();
    total++; if ({m_ce_o, m_we_o, m_addr_o} !== {2'b10, 32'h700})
      $display("FAIL rstmid_fetch_grant act=%b%b %h exp=10 00000700", m_ce_o, m_we_o, m_addr_o); else pass_cnt++;
    m_ack_i = 1'b1; m_rdata_i = 32'h33333333;
    tick();
    m_ack_i = 1'b0; if_req_i = 1'b0;
    total++; if ({if_ack_o, d_ack_o, if_rdata_o} !== {2'b10, 32'h33333333})
      $display("FAIL rstmid_fetch_ack act=%b %h exp=10 33333333", {if_ack_o, d_ack_o}, if_rdata_o); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    if_req_i = 1'b1; if_addr_i = 32'h1000;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if ({m_ce_o, m_addr_o} !== {1'b1, 32'h1000 + 32'(4 * k)})
        $display("FAIL b2b_grant_%0d act=%b %h exp=1 %h", k, m_ce_o, m_addr_o, 32'h1000 + 32'(4 * k)); else pass_cnt++;
      m_ack_i = 1'b1; m_rdata_i = 32'hA0 + 32'(k);
      tick();
      m_ack_i = 1'b0; if_addr_i = if_addr_i + 32'h4;
      total++; if ({if_ack_o, m_ce_o, if_rdata_o} !== {2'b10, 32'hA0 + 32'(k)})
        $display("FAIL b2b_ack_%0d act=%b %h exp=10 %h", k, {if_ack_o, m_ce_o}, if_rdata_o, 32'hA0 + 32'(k)); else pass_cnt++;
      tick();
      total++; if ({if_ack_o, m_ce_o} !== 2'b00)
        $display("FAIL b2b_no_dup_%0d act=%b exp=00", k, {if_ack_o, m_ce_o}); else pass_cnt++;
    end
    if_req_i = 1'b0;
    tick(); tick();
    total++; if (m_ce_o !== 1'b0) $display("FAIL b2b_quiet act=%b exp=0", m_ce_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_wait_states();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
